// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the instruction-memory bank.
//   state_e      - fill/run state of the bank controller
//   NOP_WORD_DEF - default fill word (addi x0,x0,0)
//   lane_par     - even-parity bit for one byte lane
//   addr_bad     - byte address is misaligned or beyond the array
package imem_pkg;

  typedef enum logic {
    S_FILL,
    S_RUN
  } state_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  // Even parity: the stored bit makes the total count of ones in lane+bit even.
  function automatic logic lane_par(input logic [7:0] lane);
    return ^lane;
  endfunction

  // Address is zero-extended to 64 bits by the caller; any set bit below the
  // word offset or at/above the top index bit marks the access as bad.
  function automatic logic addr_bad(input logic [63:0] addr, input int unsigned depth,
                                    input int unsigned data_w);
    int unsigned off_w;
    int unsigned top;
    logic        bad;
    off_w = $clog2(data_w / 8);
    top   = off_w + $clog2(depth);
    bad   = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i < off_w || i >= top) && addr[i]) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/imem_sram_bank_if.sv
// imem_sram_bank_if: fetch read port and program-load write port of the bank.
//   req_i/addr_i/gnt_o              - fetch request handshake
//   rvalid_o/rdata_o/err_o          - registered read response
//   wreq_i/waddr_i/wdata_i/wbe_i    - load-port write request
//   wgnt_o/werr_o                   - write accept and bad-address pulse
//   init_busy_o                     - post-reset fill in progress
// Modport slave is the memory side, master the requester side.
interface imem_sram_bank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic                  req_i;
  logic [ADDR_W-1:0]     addr_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [DATA_W-1:0]     rdata_o;
  logic                  err_o;
  logic                  wreq_i;
  logic [ADDR_W-1:0]     waddr_i;
  logic [DATA_W-1:0]     wdata_i;
  logic [DATA_W/8-1:0]   wbe_i;
  logic                  wgnt_o;
  logic                  werr_o;
  logic                  init_busy_o;

  modport slave (
    input  req_i, addr_i, wreq_i, waddr_i, wdata_i, wbe_i,
    output gnt_o, rvalid_o, rdata_o, err_o, wgnt_o, werr_o, init_busy_o
  );

  modport master (
    output req_i, addr_i, wreq_i, waddr_i, wdata_i, wbe_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, wgnt_o, werr_o, init_busy_o
  );

endinterface

// File: rtl/imem_be_array.sv
// imem_be_array: byte-enabled storage array, one write (synchronous) and one
// read (combinational, registered by the caller) per cycle.
//   clk_i      - clock
//   we_i       - write enable
//   waddr_i    - write word index
//   wdata_i    - write data
//   wbe_i      - per-lane write enables
//   raddr_i    - read word index
//   rdata_o    - stored word at raddr_i
//   par_err_o  - stored lane parity disagrees with stored data (parity build)
// Optional macro IMEM_PARITY_EN adds one even-parity bit per byte lane.
module imem_be_array
  import imem_pkg::*;
#(
  parameter int unsigned  DEPTH  = 32,
  parameter int unsigned  DATA_W = 32,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [NB-1:0]     wbe_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              par_err_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wbe_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

`ifdef IMEM_PARITY_EN
  logic par_q [DEPTH][NB];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wbe_i[k]) par_q[waddr_i][k] <= lane_par(wdata_i[8*k +: 8]);
      end
    end
  end

  always_comb begin
    par_err_o = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (par_q[raddr_i][k] != lane_par(rdata_o[8*k +: 8])) par_err_o = 1'b1;
    end
  end
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: rtl/imem_sram_bank.sv
// imem_sram_bank: single-ported instruction memory for the fetch stage.
// After reset a fill pass writes NOP_WORD into every word; only then are the
// fetch and load ports served. Writes win over reads in the same cycle.
//   clk_i  - clock (rising edge)
//   rst_i  - synchronous active-high reset, restarts the fill
//   bus    - imem_sram_bank_if.slave: fetch port (req/gnt, registered
//            rvalid/rdata/err), load port (wreq/wgnt, byte enables, werr),
//            init_busy_o
// Optional macro IMEM_PARITY_EN: per-lane parity, mismatches reported on err_o.
module imem_sram_bank
  import imem_pkg::*;
#(
  parameter int unsigned       DEPTH    = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input logic               clk_i,
  input logic               rst_i,
  imem_sram_bank_if.slave   bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  fcnt_q, fcnt_d;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              werr_q;

  logic              gnt;
  logic              wgnt;
  logic              init_busy;
  logic              rbad;
  logic              wbad;
  logic [IDX_W-1:0]  ridx;
  logic [IDX_W-1:0]  widx;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [NB-1:0]     arr_wbe;
  logic [DATA_W-1:0] arr_rdata;
  logic              par_err;

  assign ridx = bus.addr_i[OFF_W+IDX_W-1:OFF_W];
  assign widx = bus.waddr_i[OFF_W+IDX_W-1:OFF_W];
  assign rbad = addr_bad(64'(bus.addr_i), DEPTH, DATA_W);
  assign wbad = addr_bad(64'(bus.waddr_i), DEPTH, DATA_W);

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    gnt       = 1'b0;
    wgnt      = 1'b0;
    init_busy = 1'b1;
    arr_we    = 1'b0;
    arr_waddr = fcnt_q;
    arr_wdata = NOP_WORD;
    arr_wbe   = '1;
    case (state_q)
      S_FILL: begin
        arr_we = 1'b1;
        if (fcnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_RUN;
        end else begin
          fcnt_d = fcnt_q + IDX_W'(1);
        end
      end
      S_RUN: begin
        init_busy = 1'b0;
        // No grant in a reset cycle: the reset edge would drop it anyway.
        wgnt      = bus.wreq_i & ~rst_i;
        gnt       = bus.req_i & ~bus.wreq_i & ~rst_i;
        arr_we    = wgnt & ~wbad;
        arr_waddr = widx;
        arr_wdata = bus.wdata_i;
        arr_wbe   = bus.wbe_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_FILL;
      fcnt_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      rvalid_q <= gnt;
      werr_q   <= wgnt & wbad;
      // rdata/err hold their last response while no read is granted.
      if (gnt) begin
        rdata_q <= rbad ? '0 : arr_rdata;
        err_q   <= rbad | par_err;
      end
    end
  end

  imem_be_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i     (clk_i),
    .we_i      (arr_we),
    .waddr_i   (arr_waddr),
    .wdata_i   (arr_wdata),
    .wbe_i     (arr_wbe),
    .raddr_i   (ridx),
    .rdata_o   (arr_rdata),
    .par_err_o (par_err)
  );

  assign bus.gnt_o       = gnt;
  assign bus.wgnt_o      = wgnt;
  assign bus.init_busy_o = init_busy;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.werr_o      = werr_q;

endmodule

// File: tb/tb_imem_sram_bank.sv
// tb_imem_sram_bank: directed plus random stimulus for imem_sram_bank against a
// word-level reference model (memory array, fill countdown, expected response).
module tb_imem_sram_bank;

  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;

  imem_sram_bank_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  imem_sram_bank #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .ADDR_W (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_par [DEPTH];
  int          m_fill  = 0;
  logic        m_known = 1'b0;
  logic        m_rvalid, m_err, m_werr;
  logic [31:0] m_rdata;
  logic        last_gnt, last_wgnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  // One clock: check grant outputs for the current inputs, advance the model at
  // the edge, then check the registered response.
  task automatic tick();
    logic        e_busy, e_gnt, e_wgnt, bad;
    int          idx;
    #1;
    e_busy = (m_fill != 0);
    e_wgnt = !rst && !e_busy && bus.wreq_i;
    e_gnt  = !rst && !e_busy && bus.req_i && !bus.wreq_i;
    last_gnt  = bus.gnt_o;
    last_wgnt = bus.wgnt_o;
    if (m_known) begin
      chk("init_busy", bus.init_busy_o, e_busy);
      chk("gnt", bus.gnt_o, e_gnt);
      chk("wgnt", bus.wgnt_o, e_wgnt);
    end
    @(posedge clk);
    if (rst) begin
      m_known  = 1'b1;
      m_fill   = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = NOP;
        m_par[i] = 4'h0;
      end
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_err    = 1'b0;
      m_werr   = 1'b0;
    end else if (m_fill != 0) begin
      m_fill--;
      m_rvalid = 1'b0;
      m_werr   = 1'b0;
    end else begin
      m_rvalid = e_gnt;
      if (e_gnt) begin
        bad = is_bad(bus.addr_i);
        idx = int'((bus.addr_i >> 2) % DEPTH);
        m_rdata = bad ? 32'h0 : m_mem[idx];
`ifdef IMEM_PARITY_EN
        m_err = bad || (m_par[idx] != 4'h0);
`else
        m_err = bad;
`endif
      end
      bad    = is_bad(bus.waddr_i);
      m_werr = e_wgnt && bad;
      if (e_wgnt && !bad) begin
        idx = int'(bus.waddr_i >> 2);
        for (int k = 0; k < 4; k++) begin
          if (bus.wbe_i[k]) begin
            m_mem[idx][8*k +: 8] = bus.wdata_i[8*k +: 8];
            m_par[idx][k]        = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
    if (m_known) begin
      chk("rvalid", bus.rvalid_o, m_rvalid);
      chk("rdata", bus.rdata_o, m_rdata);
      chk("err", bus.err_o, m_err);
      chk("werr", bus.werr_o, m_werr);
    end
  endtask

  task automatic set_rd(input logic r, input logic [31:0] a);
    bus.req_i  = r;
    bus.addr_i = a;
  endtask

  task automatic set_wr(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    bus.wreq_i  = w;
    bus.waddr_i = a;
    bus.wdata_i = d;
    bus.wbe_i   = be;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    set_rd(1'b0, 32'h0);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    chk("reset_rvalid", bus.rvalid_o, 1'b0);
    chk("reset_rdata", bus.rdata_o, 32'h0);

    // 1: fill length with a pending read at addr 0
    rst = 1'b0;
    set_rd(1'b1, 32'h0);
    n = 0;
    while (n < 100) begin
      tick();
      if (last_gnt) break;
      n++;
    end
    chk("t1_fill_cycles", n, 32);
    chk("t1_rvalid", bus.rvalid_o, 1'b1);
    chk("t1_rdata", bus.rdata_o, NOP);
    chk("t1_err", bus.err_o, 1'b0);
    set_rd(1'b0, 32'h0);
    tick();

    // 2: full write then single-lane merge
    set_wr(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111);
    tick();
    set_wr(1'b1, 32'h10, 32'h0000_5500, 4'b0010);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h10);
    tick();
    chk("t2_rdata", bus.rdata_o, 32'hDEAD_55EF);

    // 3: write beats read in the same cycle, read follows with new data
    set_wr(1'b1, 32'h20, 32'h1234_5678, 4'b1111);
    set_rd(1'b1, 32'h20);
    tick();
    chk("t3_gnt_blocked", last_gnt, 1'b0);
    chk("t3_wgnt", last_wgnt, 1'b1);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("t3_gnt_next", last_gnt, 1'b1);
    chk("t3_raw_data", bus.rdata_o, 32'h1234_5678);

    // 4: bad reads, bad write, and a granted write with no lanes enabled
    set_rd(1'b1, 32'h82);
    tick();
    chk("t4_mis_rdata", bus.rdata_o, 32'h0);
    chk("t4_mis_err", bus.err_o, 1'b1);
    set_rd(1'b1, 32'h80);
    tick();
    chk("t4_oor_rdata", bus.rdata_o, 32'h0);
    chk("t4_oor_err", bus.err_o, 1'b1);
    set_rd(1'b0, 32'h0);
    set_wr(1'b1, 32'h80, 32'hFFFF_FFFF, 4'b1111);
    tick();
    chk("t4_werr", bus.werr_o, 1'b1);
    set_wr(1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0000);
    tick();
    chk("t4_werr_clear", bus.werr_o, 1'b0);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(1'b1, 32'(i * 4));
      tick();
    end
    chk("t4_wbe0_word", bus.rdata_o, NOP);

    // 5: back-to-back stream, then reset mid-stream
    n = 0;
    for (int i = 0; i < 8; i++) begin
      set_rd(1'b1, 32'(i * 4));
      tick();
      if (bus.rvalid_o === 1'b1) n++;
    end
    chk("t5_stream_valid", n, 8);
    chk("t5_last_data", bus.rdata_o, NOP);
    for (int i = 0; i < 3; i++) begin
      set_rd(1'b1, 32'(i * 4));
      tick();
    end
    rst = 1'b1;
    tick();
    chk("t5_rst_rvalid", bus.rvalid_o, 1'b0);
    rst = 1'b0;
    set_rd(1'b1, 32'h0);
    n = 0;
    while (n < 100) begin
      tick();
      if (last_gnt) break;
      n++;
    end
    chk("t5_refill_cycles", n, 32);
    chk("t5_refill_data", bus.rdata_o, NOP);

    // 6: parity corruption on word 3, lane 0
`ifdef IMEM_PARITY_EN
    dut.u_array.par_q[3][0] = ~dut.u_array.par_q[3][0];
    m_par[3][0] = ~m_par[3][0];
`endif
    set_rd(1'b1, 32'h0C);
    tick();
    chk("t6_rvalid", bus.rvalid_o, 1'b1);
    chk("t6_rdata", bus.rdata_o, NOP);
`ifdef IMEM_PARITY_EN
    chk("t6_err", bus.err_o, 1'b1);
`else
    chk("t6_err", bus.err_o, 1'b0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_rd($urandom_range(0, 3) != 0,
             ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 32'h9F))
                                         : 32'($urandom_range(0, DEPTH - 1) * 4));
      set_wr($urandom_range(0, 2) == 0,
             ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 32'h9F))
                                         : 32'($urandom_range(0, DEPTH - 1) * 4),
             $urandom, 4'($urandom_range(0, 15)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_sram_bank.md
Name: imem_sram_bank

Overview:
- Parametrised single-port instruction memory for the core's fetch stage.
- Has two request ports sharing one array:
  - a fetch read port with a req/gnt handshake and registered 1-cycle read data;
  - a program-load write port with byte enables.
- After reset, an internal fill FSM writes NOP_WORD to every location before either port is served, so the core never fetches undefined contents.
- Addresses are byte addresses. Misaligned or out-of-range accesses produce an error response instead of aliasing.

Parameters:
DEPTH, 32, number of words; power of two, >= 2
DATA_W, 32, word width in bits; multiple of 8
ADDR_W, 32, byte-address width on both ports
NOP_WORD, 32'h0000_0013, fill value written after reset (addi x0,x0,0); width DATA_W

Ports:
clk_i  in  1  clock, all logic on the rising edge
rst_i  in  1  reset, synchronous and active-high
req_i  in  1  fetch read request
addr_i  in  ADDR_W  fetch byte address
gnt_o  out  1  fetch request accepted this cycle
rvalid_o  out  1  read response valid (1 cycle after the grant)
rdata_o  out  DATA_W  read data, registered
err_o  out  1  read response error, qualified by rvalid_o
wreq_i  in  1  load-port write request
waddr_i  in  ADDR_W  load-port byte address
wdata_i  in  DATA_W  write data
wbe_i  in  DATA_W/8  byte enables, lane k maps to wdata_i[8k+7:8k]
wgnt_o  out  1  write accepted this cycle
werr_o  out  1  pulses 1 cycle after an accepted bad write
init_busy_o  out  1  fill FSM active

Behaviour:
- Derived constants: OFF_W = $clog2(DATA_W/8); IDX_W = $clog2(DEPTH). Word index = addr[OFF_W+IDX_W-1:OFF_W].
- Bad address: addr[OFF_W-1:0] != 0, or any bit at or above OFF_W+IDX_W set.
- States:
  - S_FILL: fill counter fcnt writes NOP_WORD (all lanes) to word fcnt, one word per cycle. When fcnt == DEPTH-1, go to S_RUN on the next edge. Fill takes DEPTH cycles.
  - S_RUN: normal operation. The block stays in S_RUN until rst_i.
- Reset (rst_i sampled high at an edge):
  - state = S_FILL, fcnt = 0;
  - gnt_o = 0, wgnt_o = 0, rvalid_o = 0, err_o = 0, werr_o = 0, rdata_o = 0;
  - init_busy_o = 1.
  - Reset during S_FILL or S_RUN restarts the fill from word 0. Any in-flight read response is dropped (rvalid_o = 0).
- In S_FILL: gnt_o = 0, wgnt_o = 0, init_busy_o = 1. Requests are held off, not lost; the requester keeps them asserted.
- In S_RUN, gnt_o, wgnt_o and init_busy_o are combinational from state and requests:
  - wgnt_o = wreq_i; gnt_o = req_i & ~wreq_i (write has priority, single-ported array); init_busy_o = 0.
- Accepted read (req_i & gnt_o) at edge N:
  - at N+1, rvalid_o = 1;
  - rdata_o = array[index], or 0 with err_o = 1 if the address is bad.
- rvalid_o deasserts the cycle after a response when no new grant occurs. rdata_o and err_o hold their last value while rvalid_o = 0.
- Back-to-back grants give one response per cycle with no bubble.
- Accepted write: only lanes with wbe_i[k] = 1 are updated.
  - wbe_i = 0: the write is granted but has no effect.
  - Bad address: the array is unchanged and werr_o = 1 for one cycle at N+1.
- Read-after-write: a write at edge N followed by a read of the same word granted at edge N+1 returns the new data at N+2.
- A read and a write are never performed in the same cycle.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - The block keeps one even-parity bit per byte lane, stored in par_q[DEPTH][DATA_W/8].
  - Parity is written with its lane on every write, including fill writes.
  - On a granted good-address read, the stored parity is compared with parity recomputed from the data. Any lane mismatch sets err_o = 1 with rvalid_o; rdata_o still carries the stored data.
- Undefined:
  - No parity storage.
  - err_o reflects address errors only.

Decomposition:
- Package imem_pkg:
  - state enum (S_FILL, S_RUN);
  - default NOP_WORD constant;
  - function computing per-lane parity;
  - function addr_bad (inputs: address, DEPTH, DATA_W).
- One sub-module: imem_be_array.
  - A plain byte-enabled synchronous array with one write and one read per cycle, exclusive.
  - Optional parity columns are also held here.
- The top level holds the FSM, arbitration, address checks and response registers.

Test Plan:
1. Release rst_i, hold req_i = 1 at addr 0 -> init_busy_o = 1 and gnt_o = 0 for exactly 32 cycles; first grant on cycle 33; response 32'h0000_0013, err_o = 0.
2. After the fill, write 32'hDEAD_BEEF with wbe 4'b1111 to addr 0x10, then wbe 4'b0010 with data 32'h0000_5500 -> read of 0x10 returns 32'hDEAD_55EF.
3. Same cycle: wreq_i = 1 and req_i = 1 -> wgnt_o = 1, gnt_o = 0. Next cycle the read is granted and returns the just-written data.
4. Read addr 0x82 (misaligned), then 0x80 (out of range for DEPTH = 32) -> two responses with rdata_o = 0, err_o = 1. A write to 0x80 gives a werr_o pulse and leaves all words unchanged.
5. Stream of 8 back-to-back reads of addresses 0x00..0x1C -> rvalid_o high for 8 consecutive cycles, data in order. Assert rst_i mid-stream -> rvalid_o = 0 next cycle and a 32-cycle refill follows.
6. With IMEM_PARITY_EN: flip par_q[3][0] by backdoor, read addr 0x0C -> err_o = 1 with rvalid_o and rdata_o = 32'h0000_0013. Without the macro, the same read gives err_o = 0.
